// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   Consumer side of the ID/EX pipeline register. Resolves operands through the
//   EX/MEM and MEM/WB forwarding network, computes the ALU result (or runs an
//   iterative shift-add multiply) and owns the EX/MEM pipeline register.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   IDEX_*                decoded instruction bundle from the ID/EX register
//   MEMWB_rd/_WriteBack/_data  write-back stage forwarding source
//   EXMEM_*               registered EX/MEM pipeline outputs
//   MEMEX_WriteBack       copy of EXMEM_alu_result, forward path to decode
//   ex_stall              freezes fetch, IF/ID and ID/EX while a multiply runs
// -----------------------------------------------------------------------------
module execute_stage #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      IDEX_rs1,
  input  logic [4:0]      IDEX_rs2,
  input  logic [4:0]      IDEX_rd,
  input  logic [XLEN-1:0] IDEX_imm,
  input  logic [XLEN-1:0] IDEX_read_data1,
  input  logic [XLEN-1:0] IDEX_read_data2,
  input  logic            IDEX_WriteBack,
  input  logic            IDEX_MemoryRead,
  input  logic            IDEX_MemoryWrite,
  input  logic            IDEX_Execution,
  input  logic [3:0]      IDEX_aluOP,
  input  logic [1:0]      IDEX_aluOP_2,
  input  logic            IDEX_AluSrc,
  input  logic [4:0]      MEMWB_rd,
  input  logic            MEMWB_WriteBack,
  input  logic [XLEN-1:0] MEMWB_data,
  output logic [4:0]      EXMEM_rd,
  output logic [XLEN-1:0] EXMEM_alu_result,
  output logic [XLEN-1:0] EXMEM_store_data,
  output logic            EXMEM_WriteBack,
  output logic            EXMEM_MemoryRead,
  output logic            EXMEM_MemoryWrite,
  output logic [XLEN-1:0] MEMEX_WriteBack,
  output logic            ex_stall
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // EX/MEM pipeline register
  logic [4:0]      exmem_rd_q, exmem_rd_d;
  logic [XLEN-1:0] exmem_alu_q, exmem_alu_d;
  logic [XLEN-1:0] exmem_st_q, exmem_st_d;
  logic            exmem_wb_q, exmem_wb_d;
  logic            exmem_mr_q, exmem_mr_d;
  logic            exmem_mw_q, exmem_mw_d;

  // Multiplier state: operands and destination are held for the whole run
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mul_st_q, mul_st_d;
  logic [4:0]      mul_rd_q, mul_rd_d;
  logic            mul_wb_q, mul_wb_d;
  logic            mul_mr_q, mul_mr_d;
  logic            mul_mw_q, mul_mw_d;

  logic [XLEN-1:0] fwd_a_s, fwd_b_s, op_b_s, alu_res_s;
  logic [4:0]      shamt_s;
  logic            mul_start_s;
  logic            ex_stall_s;

  assign op_b_s  = IDEX_AluSrc ? IDEX_imm : fwd_b_s;
  assign shamt_s = op_b_s[4:0];
  assign mul_start_s = MUL_EN && (state_q == IDLE) && IDEX_Execution &&
                       (IDEX_aluOP_2 == 2'b00) && (IDEX_aluOP == 4'd10);

  // Operand A forwarding: EX/MEM (non-load) beats MEM/WB, x0 never forwarded
  always_comb begin
    fwd_a_s = IDEX_read_data1;
    if (exmem_wb_q && !exmem_mr_q && (exmem_rd_q != 5'd0) && (exmem_rd_q == IDEX_rs1)) begin
      fwd_a_s = exmem_alu_q;
    end else if (MEMWB_WriteBack && (MEMWB_rd != 5'd0) && (MEMWB_rd == IDEX_rs1)) begin
      fwd_a_s = MEMWB_data;
    end else begin
      fwd_a_s = IDEX_read_data1;
    end
  end

  // Operand B (rs2) forwarding, same priority as operand A
  always_comb begin
    fwd_b_s = IDEX_read_data2;
    if (exmem_wb_q && !exmem_mr_q && (exmem_rd_q != 5'd0) && (exmem_rd_q == IDEX_rs2)) begin
      fwd_b_s = exmem_alu_q;
    end else if (MEMWB_WriteBack && (MEMWB_rd != 5'd0) && (MEMWB_rd == IDEX_rs2)) begin
      fwd_b_s = MEMWB_data;
    end else begin
      fwd_b_s = IDEX_read_data2;
    end
  end

  // Single-cycle ALU; MUL falls back to ADD here (real product comes from the FSM)
  always_comb begin
    alu_res_s = fwd_a_s + op_b_s;
    case (IDEX_aluOP_2)
      2'b00: begin
        case (IDEX_aluOP)
          4'd0:    alu_res_s = fwd_a_s + op_b_s;
          4'd1:    alu_res_s = fwd_a_s - op_b_s;
          4'd2:    alu_res_s = fwd_a_s << shamt_s;
          4'd3:    alu_res_s = {{(XLEN-1){1'b0}}, ($signed(fwd_a_s) < $signed(op_b_s))};
          4'd4:    alu_res_s = {{(XLEN-1){1'b0}}, (fwd_a_s < op_b_s)};
          4'd5:    alu_res_s = fwd_a_s ^ op_b_s;
          4'd6:    alu_res_s = fwd_a_s >> shamt_s;
          4'd7:    alu_res_s = $unsigned($signed(fwd_a_s) >>> shamt_s);
          4'd8:    alu_res_s = fwd_a_s | op_b_s;
          4'd9:    alu_res_s = fwd_a_s & op_b_s;
          default: alu_res_s = fwd_a_s + op_b_s;
        endcase
      end
      2'b01:   alu_res_s = IDEX_imm;
      default: alu_res_s = fwd_a_s + op_b_s;
    endcase
  end

  // Multiply FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Multiply FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mul_start_s) state_d = BUSY;
        else             state_d = IDLE;
      end
      BUSY: begin
        if (cnt_q == LAST_STEP) state_d = DONE;
        else                    state_d = BUSY;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Multiply FSM output: stall from MUL acceptance through the last BUSY step
  always_comb begin
    ex_stall_s = 1'b0;
    case (state_q)
      IDLE:    ex_stall_s = rst_n && mul_start_s;
      BUSY:    ex_stall_s = rst_n;
      DONE:    ex_stall_s = 1'b0;
      default: ex_stall_s = 1'b0;
    endcase
  end

  // Multiplier datapath: latch operands on acceptance, one shift-add per BUSY cycle
  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mul_st_d = mul_st_q;
    mul_rd_d = mul_rd_q;
    mul_wb_d = mul_wb_q;
    mul_mr_d = mul_mr_q;
    mul_mw_d = mul_mw_q;
    if (mul_start_s) begin
      cnt_d    = {CW{1'b0}};
      mcand_d  = fwd_a_s;
      mplier_d = op_b_s;
      acc_d    = {XLEN{1'b0}};
      mul_st_d = fwd_b_s;
      mul_rd_d = IDEX_rd;
      mul_wb_d = IDEX_WriteBack;
      mul_mr_d = IDEX_MemoryRead;
      mul_mw_d = IDEX_MemoryWrite;
    end else if (state_q == BUSY) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : {XLEN{1'b0}});
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end else begin
      cnt_d    = cnt_q;
    end
  end

  // Multiplier registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= {CW{1'b0}};
      mcand_q  <= {XLEN{1'b0}};
      mplier_q <= {XLEN{1'b0}};
      acc_q    <= {XLEN{1'b0}};
      mul_st_q <= {XLEN{1'b0}};
      mul_rd_q <= 5'd0;
      mul_wb_q <= 1'b0;
      mul_mr_q <= 1'b0;
      mul_mw_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mul_st_q <= mul_st_d;
      mul_rd_q <= mul_rd_d;
      mul_wb_q <= mul_wb_d;
      mul_mr_q <= mul_mr_d;
      mul_mw_q <= mul_mw_d;
    end
  end

  // EX/MEM next value: product in DONE, bubble while stalled or on invalid slot
  always_comb begin
    exmem_rd_d  = IDEX_rd;
    exmem_alu_d = alu_res_s;
    exmem_st_d  = fwd_b_s;
    exmem_wb_d  = IDEX_WriteBack;
    exmem_mr_d  = IDEX_MemoryRead;
    exmem_mw_d  = IDEX_MemoryWrite;
    if (state_q == DONE) begin
      exmem_rd_d  = mul_rd_q;
      exmem_alu_d = acc_q;
      exmem_st_d  = mul_st_q;
      exmem_wb_d  = mul_wb_q;
      exmem_mr_d  = mul_mr_q;
      exmem_mw_d  = mul_mw_q;
    end else if (ex_stall_s) begin
      // data fields simply hold; only the controls matter for a bubble
      exmem_rd_d  = exmem_rd_q;
      exmem_alu_d = exmem_alu_q;
      exmem_st_d  = exmem_st_q;
      exmem_wb_d  = 1'b0;
      exmem_mr_d  = 1'b0;
      exmem_mw_d  = 1'b0;
    end else if (!IDEX_Execution) begin
      exmem_wb_d  = 1'b0;
      exmem_mr_d  = 1'b0;
      exmem_mw_d  = 1'b0;
    end else begin
      exmem_wb_d  = IDEX_WriteBack;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_rd_q  <= 5'd0;
      exmem_alu_q <= {XLEN{1'b0}};
      exmem_st_q  <= {XLEN{1'b0}};
      exmem_wb_q  <= 1'b0;
      exmem_mr_q  <= 1'b0;
      exmem_mw_q  <= 1'b0;
    end else begin
      exmem_rd_q  <= exmem_rd_d;
      exmem_alu_q <= exmem_alu_d;
      exmem_st_q  <= exmem_st_d;
      exmem_wb_q  <= exmem_wb_d;
      exmem_mr_q  <= exmem_mr_d;
      exmem_mw_q  <= exmem_mw_d;
    end
  end

  assign EXMEM_rd          = exmem_rd_q;
  assign EXMEM_alu_result  = exmem_alu_q;
  assign EXMEM_store_data  = exmem_st_q;
  assign EXMEM_WriteBack   = exmem_wb_q;
  assign EXMEM_MemoryRead  = exmem_mr_q;
  assign EXMEM_MemoryWrite = exmem_mw_q;
  assign MEMEX_WriteBack   = exmem_alu_q;
  assign ex_stall          = ex_stall_s;

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
//   Self-checking bench for execute_stage: directed cases for reset, ALU ops,
//   forwarding, bubbles and the multi-cycle multiply, then randomized
//   single-cycle traffic against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_execute_stage;

  logic        clk;
  logic        rst_n;
  logic [4:0]  IDEX_rs1, IDEX_rs2, IDEX_rd;
  logic [31:0] IDEX_imm, IDEX_read_data1, IDEX_read_data2;
  logic        IDEX_WriteBack, IDEX_MemoryRead, IDEX_MemoryWrite, IDEX_Execution;
  logic [3:0]  IDEX_aluOP;
  logic [1:0]  IDEX_aluOP_2;
  logic        IDEX_AluSrc;
  logic [4:0]  MEMWB_rd;
  logic        MEMWB_WriteBack;
  logic [31:0] MEMWB_data;
  logic [4:0]  EXMEM_rd;
  logic [31:0] EXMEM_alu_result, EXMEM_store_data, MEMEX_WriteBack;
  logic        EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite, ex_stall;

  int err_cnt;
  int chk_cnt;

  // expected EX/MEM contents for the random section
  logic [4:0]  m_rd;
  logic [31:0] m_res;
  logic        m_wb, m_mr;

  execute_stage #(.XLEN(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .IDEX_rs1(IDEX_rs1), .IDEX_rs2(IDEX_rs2), .IDEX_rd(IDEX_rd),
    .IDEX_imm(IDEX_imm), .IDEX_read_data1(IDEX_read_data1), .IDEX_read_data2(IDEX_read_data2),
    .IDEX_WriteBack(IDEX_WriteBack), .IDEX_MemoryRead(IDEX_MemoryRead),
    .IDEX_MemoryWrite(IDEX_MemoryWrite), .IDEX_Execution(IDEX_Execution),
    .IDEX_aluOP(IDEX_aluOP), .IDEX_aluOP_2(IDEX_aluOP_2), .IDEX_AluSrc(IDEX_AluSrc),
    .MEMWB_rd(MEMWB_rd), .MEMWB_WriteBack(MEMWB_WriteBack), .MEMWB_data(MEMWB_data),
    .EXMEM_rd(EXMEM_rd), .EXMEM_alu_result(EXMEM_alu_result), .EXMEM_store_data(EXMEM_store_data),
    .EXMEM_WriteBack(EXMEM_WriteBack), .EXMEM_MemoryRead(EXMEM_MemoryRead),
    .EXMEM_MemoryWrite(EXMEM_MemoryWrite), .MEMEX_WriteBack(MEMEX_WriteBack),
    .ex_stall(ex_stall)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [3:0] o,
                       input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] r2, input logic [31:0] d2,
                       input logic [4:0] rd, input logic [31:0] imm, input logic src);
    IDEX_aluOP_2 = c;  IDEX_aluOP = o;
    IDEX_rs1 = r1;     IDEX_read_data1 = d1;
    IDEX_rs2 = r2;     IDEX_read_data2 = d2;
    IDEX_rd = rd;      IDEX_imm = imm;  IDEX_AluSrc = src;
    IDEX_Execution = 1'b1; IDEX_WriteBack = 1'b1;
    IDEX_MemoryRead = 1'b0; IDEX_MemoryWrite = 1'b0;
    MEMWB_WriteBack = 1'b0; MEMWB_rd = 5'd0; MEMWB_data = 32'd0;
    #1;
  endtask

  task automatic bubble();
    IDEX_Execution = 1'b0;
    IDEX_WriteBack = 1'b1;
    MEMWB_WriteBack = 1'b0;
    #1;
  endtask

  // MUL already presented: count stalled cycles, then check the product
  task automatic run_mul(input string tag, input logic [31:0] exp, input logic [4:0] rd);
    int n;
    n = 0;
    check_eq({tag, "_stall_start"}, {31'd0, ex_stall}, 32'd1);
    while (ex_stall === 1'b1 && n < 100) begin
      step();
      n++;
      check_eq({tag, "_bubble_wb"}, {31'd0, EXMEM_WriteBack}, 32'd0);
    end
    check_eq({tag, "_stall_len"}, 32'(n), 32'd33);
    step();
    check_eq({tag, "_result"}, EXMEM_alu_result, exp);
    check_eq({tag, "_wb"}, {31'd0, EXMEM_WriteBack}, 32'd1);
    check_eq({tag, "_rd"}, {27'd0, EXMEM_rd}, {27'd0, rd});
  endtask

  function automatic logic [31:0] ref_alu(input logic [1:0] c, input logic [3:0] o,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] imm);
    logic [4:0] sh;
    sh = b[4:0];
    if (c == 2'b01) return imm;
    if (c != 2'b00) return a + b;
    case (o)
      4'd1:    return a - b;
      4'd2:    return a << sh;
      4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> sh;
      4'd7:    return $unsigned($signed(a) >>> sh);
      4'd8:    return a | b;
      4'd9:    return a & b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (m_wb && !m_mr && m_rd != 5'd0 && m_rd == rs) return m_res;
    if (MEMWB_WriteBack && MEMWB_rd != 5'd0 && MEMWB_rd == rs) return MEMWB_data;
    return rf;
  endfunction

  initial begin
    logic [31:0] a, r2, b, res;
    logic        ex, wb, mr, mw;
    err_cnt = 0;
    chk_cnt = 0;
    rst_n = 1'b0;
    drive(2'b00, 4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
    #10;
    check_eq("rst_wb", {31'd0, EXMEM_WriteBack}, 32'd0);
    check_eq("rst_alu", EXMEM_alu_result, 32'd0);
    check_eq("rst_stall", {31'd0, ex_stall}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // ADD x1(5) + imm 7
    drive(2'b00, 4'd0, 5'd1, 32'd5, 5'd2, 32'd0, 5'd12, 32'd7, 1'b1);
    step();
    check_eq("add_imm", EXMEM_alu_result, 32'd12);
    check_eq("add_wb", {31'd0, EXMEM_WriteBack}, 32'd1);
    check_eq("memex", MEMEX_WriteBack, 32'd12);

    // asynchronous reset mid-cycle
    rst_n = 1'b0;
    #2;
    check_eq("async_rst_alu", EXMEM_alu_result, 32'd0);
    check_eq("async_rst_wb", {31'd0, EXMEM_WriteBack}, 32'd0);
    check_eq("async_rst_rd", {27'd0, EXMEM_rd}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // SUB 3 - 5
    drive(2'b00, 4'd1, 5'd1, 32'd3, 5'd2, 32'd5, 5'd12, 32'd0, 1'b0);
    step();
    check_eq("sub", EXMEM_alu_result, 32'hFFFF_FFFE);

    // EX/MEM forward with MEM/WB also targeting x3: EX/MEM wins
    drive(2'b00, 4'd0, 5'd1, 32'd10, 5'd2, 32'd20, 5'd3, 32'd0, 1'b0);
    step();
    check_eq("fwd_add", EXMEM_alu_result, 32'd30);
    drive(2'b00, 4'd1, 5'd3, 32'd999, 5'd1, 32'd10, 5'd4, 32'd0, 1'b0);
    MEMWB_WriteBack = 1'b1; MEMWB_rd = 5'd3; MEMWB_data = 32'd77; #1;
    step();
    check_eq("fwd_exmem_prio", EXMEM_alu_result, 32'd20);
    check_eq("fwd_store", EXMEM_store_data, 32'd10);
    // MEM/WB only
    drive(2'b00, 4'd0, 5'd2, 32'd1, 5'd9, 32'd0, 5'd5, 32'd1, 1'b1);
    MEMWB_WriteBack = 1'b1; MEMWB_rd = 5'd2; MEMWB_data = 32'd100; #1;
    step();
    check_eq("fwd_memwb", EXMEM_alu_result, 32'd101);
    // x0 never forwarded
    drive(2'b00, 4'd0, 5'd1, 32'd50, 5'd9, 32'd0, 5'd0, 32'd0, 1'b1);
    step();
    drive(2'b00, 4'd0, 5'd0, 32'd0, 5'd9, 32'd0, 5'd6, 32'd3, 1'b1);
    MEMWB_WriteBack = 1'b1; MEMWB_rd = 5'd0; MEMWB_data = 32'd9; #1;
    step();
    check_eq("fwd_x0", EXMEM_alu_result, 32'd3);

    // shifts and compares
    drive(2'b00, 4'd7, 5'd10, 32'h8000_0000, 5'd11, 32'd0, 5'd12, 32'd4, 1'b1);
    step();
    check_eq("sra", EXMEM_alu_result, 32'hF800_0000);
    drive(2'b00, 4'd4, 5'd10, 32'd1, 5'd11, 32'hFFFF_FFFF, 5'd12, 32'd0, 1'b0);
    step();
    check_eq("sltu", EXMEM_alu_result, 32'd1);
    drive(2'b00, 4'd3, 5'd10, 32'd1, 5'd11, 32'hFFFF_FFFF, 5'd12, 32'd0, 1'b0);
    step();
    check_eq("slt", EXMEM_alu_result, 32'd0);

    // bubble with WriteBack asserted on the inputs
    bubble();
    step();
    check_eq("bubble_wb", {31'd0, EXMEM_WriteBack}, 32'd0);

    // back-to-back MUL
    drive(2'b00, 4'd10, 5'd6, 32'h0001_0003, 5'd7, 32'd7, 5'd8, 32'd0, 1'b0);
    run_mul("mul1", 32'h0007_0015, 5'd8);
    drive(2'b00, 4'd10, 5'd6, 32'hFFFF_FFFF, 5'd7, 32'd2, 5'd9, 32'd0, 1'b0);
    run_mul("mul2", 32'hFFFF_FFFE, 5'd9);
    bubble();
    step();

    // reset pulsed during BUSY abandons the multiply
    drive(2'b00, 4'd10, 5'd6, 32'd3, 5'd7, 32'd4, 5'd8, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    check_eq("busy_stall", {31'd0, ex_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("busy_rst_stall", {31'd0, ex_stall}, 32'd0);
    check_eq("busy_rst_wb", {31'd0, EXMEM_WriteBack}, 32'd0);
    bubble();
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      check_eq("abandon_wb", {31'd0, EXMEM_WriteBack}, 32'd0);
      check_eq("abandon_stall", {31'd0, ex_stall}, 32'd0);
    end

    // randomized single-cycle traffic vs. reference model
    m_wb = 1'b0; m_mr = 1'b0; m_rd = 5'd0; m_res = 32'd0;
    for (int i = 0; i < 300; i++) begin
      ex = ($urandom_range(7) != 0);
      wb = 1'($urandom_range(1));
      mr = 1'($urandom_range(1));
      mw = 1'($urandom_range(1));
      IDEX_Execution = ex; IDEX_WriteBack = wb;
      IDEX_MemoryRead = mr; IDEX_MemoryWrite = mw;
      IDEX_aluOP_2 = 2'($urandom_range(3));
      IDEX_aluOP = 4'($urandom_range(15));
      if (IDEX_aluOP == 4'd10) IDEX_aluOP = 4'd11;
      IDEX_rs1 = 5'($urandom_range(3));
      IDEX_rs2 = 5'($urandom_range(3));
      IDEX_rd  = 5'($urandom_range(3));
      IDEX_read_data1 = $urandom;
      IDEX_read_data2 = $urandom;
      IDEX_imm = ($urandom_range(1) == 1) ? 32'($urandom_range(40)) : $urandom;
      IDEX_AluSrc = 1'($urandom_range(1));
      MEMWB_WriteBack = 1'($urandom_range(1));
      MEMWB_rd = 5'($urandom_range(3));
      MEMWB_data = $urandom;
      #1;
      a   = ref_fwd(IDEX_rs1, IDEX_read_data1);
      r2  = ref_fwd(IDEX_rs2, IDEX_read_data2);
      b   = IDEX_AluSrc ? IDEX_imm : r2;
      res = ref_alu(IDEX_aluOP_2, IDEX_aluOP, a, b, IDEX_imm);
      check_eq("rnd_stall", {31'd0, ex_stall}, 32'd0);
      step();
      check_eq("rnd_wb", {31'd0, EXMEM_WriteBack}, {31'd0, ex & wb});
      check_eq("rnd_mr", {31'd0, EXMEM_MemoryRead}, {31'd0, ex & mr});
      check_eq("rnd_mw", {31'd0, EXMEM_MemoryWrite}, {31'd0, ex & mw});
      if (ex) begin
        check_eq("rnd_res", EXMEM_alu_result, res);
        check_eq("rnd_store", EXMEM_store_data, r2);
        check_eq("rnd_rd", {27'd0, EXMEM_rd}, {27'd0, IDEX_rd});
      end
      m_wb  = ex & wb;
      m_mr  = ex & mr;
      m_rd  = IDEX_rd;
      m_res = res;
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Consumer side of the ID/EX pipeline register. Reads the IDEX_* bundle and resolves operands through an EX/MEM and MEM/WB forwarding network.
- Computes the ALU result, or runs an iterative multi-cycle multiply, and owns the EX/MEM pipeline register.
- Returns the EX/MEM result to decode on MEMEX_WriteBack. Raises ex_stall to freeze fetch, IF/ID and ID/EX while a multiply is in progress.

Parameters:
XLEN, 32, datapath width
MUL_EN, 1, 1 = MUL op supported; 0 = MUL op executes as ADD with no stall

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
IDEX_rs1  in  5  source register 1 index
IDEX_rs2  in  5  source register 2 index
IDEX_rd  in  5  destination register index
IDEX_imm  in  XLEN  sign-extended immediate
IDEX_read_data1  in  XLEN  register-file value for rs1
IDEX_read_data2  in  XLEN  register-file value for rs2
IDEX_WriteBack  in  1  instruction writes rd
IDEX_MemoryRead  in  1  load
IDEX_MemoryWrite  in  1  store
IDEX_Execution  in  1  1 = valid instruction, 0 = bubble
IDEX_aluOP  in  4  ALU operation
IDEX_aluOP_2  in  2  operation class
IDEX_AluSrc  in  1  operand B select: 1 = imm, 0 = rs2
MEMWB_rd  in  5  MEM/WB destination index
MEMWB_WriteBack  in  1  MEM/WB writes rd
MEMWB_data  in  XLEN  MEM/WB write-back value
EXMEM_rd  out  5  registered destination index
EXMEM_alu_result  out  XLEN  registered result or address
EXMEM_store_data  out  XLEN  registered forwarded rs2 value
EXMEM_WriteBack  out  1  registered control
EXMEM_MemoryRead  out  1  registered control
EXMEM_MemoryWrite  out  1  registered control
MEMEX_WriteBack  out  XLEN  equals EXMEM_alu_result, forward path to decode
ex_stall  out  1  hold upstream stages

Behaviour:
- Reset (rst_n low, asynchronous): all EXMEM_* outputs 0, FSM to IDLE, multiply counter 0, ex_stall 0. Reset mid-multiply abandons the operation and produces no write-back.
- Forwarding, applied independently to rs1 and rs2:
  - Select EXMEM_alu_result if EXMEM_WriteBack=1, EXMEM_MemoryRead=0, EXMEM_rd!=0 and EXMEM_rd==rs.
  - Otherwise select MEMWB_data if MEMWB_WriteBack=1, MEMWB_rd!=0 and MEMWB_rd==rs.
  - Otherwise use IDEX_read_data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
  - Load-use hazards are handled by decode, not here.
- Operand B: IDEX_AluSrc ? IDEX_imm : forwarded rs2.
- aluOP_2 decode:
  - 00: ALU op selected by aluOP.
  - 01: pass IDEX_imm.
  - 10: ADD (load/store address).
  - 11: ADD.
- aluOP encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11-15 ADD.
- Arithmetic rules:
  - Shift amount is B[4:0].
  - SLT and SLTU return 0 or 1.
  - All arithmetic wraps modulo 2^XLEN.
  - MUL returns the low XLEN bits of the product.
- Single-cycle ops: EX/MEM captures the result, forwarded rs2, rd and controls on every edge where ex_stall=0. If IDEX_Execution=0, EX/MEM captures WriteBack, MemoryRead and MemoryWrite as 0 (bubble); data fields are don't-care.
- Multiply FSM, states IDLE, BUSY, DONE:
  - IDLE: on Execution=1, aluOP_2=00, aluOP=10 and MUL_EN=1, latch the forwarded operands, clear the accumulator and count, go to BUSY. ex_stall=1 combinationally in this cycle.
  - BUSY: one shift-add step per cycle. ex_stall=1. After step XLEN-1 (count==XLEN-1), go to DONE.
  - DONE: ex_stall=0. EX/MEM captures the product with the held rd and controls, then go to IDLE.
  - Total stall is XLEN+1 cycles, and the result is visible on EXMEM_alu_result XLEN+2 edges after the MUL is first presented.
  - Every edge with ex_stall=1 writes a bubble into EX/MEM.
  - Upstream holds IDEX_* constant while ex_stall=1. Operands are not re-sampled, so the latched operands are used even if the MEM/WB forward source retires during the stall.
- Back-to-back MUL: DONE returns to IDLE, which accepts the next MUL in the following cycle.

Test Plan:
- Reset: drive rst_n=0 mid-operation -> all EXMEM_* = 0, ex_stall=0 immediately, without waiting for a clock edge.
- ADD with x1=5 (register file), imm=7, AluSrc=1 -> EXMEM_alu_result=12 after 1 edge; SUB 3-5 -> 0xFFFFFFFE.
- EX/MEM forward: ADD x3=x1+x2 followed by SUB x4=x3-x1 with stale register-file x3 -> SUB uses the new x3. When MEM/WB also targets x3, EX/MEM wins. rd=0 is never forwarded.
- Shifts and compares: SRA 0x80000000>>4 -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT -> 0.
- MUL 0x0001_0003 * 0x0000_0007 -> ex_stall high for exactly 33 cycles with a bubble in EX/MEM each cycle, then 0x0007_0015 with WriteBack=1; immediate second MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
- Bubble (IDEX_Execution=0) with WriteBack=1 on the inputs -> EXMEM_WriteBack=0; rst_n pulsed during BUSY -> FSM IDLE, no write-back.
